// File: rtl/ram_pkg.sv
// Shared definitions for the DRAM sequencer: state encoding and timing defaults.
package ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAS,
    CAS,
    PRE,
    REFCAS,
    REFRAS
  } ramState_t;

  localparam int TRP_DEFAULT      = 2;
  localparam int TRAS_REF_DEFAULT = 3;

endpackage

// File: rtl/ram_ctrl.sv
// DRAM sequencer/arbiter: shares the array between 68000 bus cycles and
// CAS-before-RAS refresh. Every output is driven from a register.
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int TRP      = TRP_DEFAULT,
  parameter int TRAS_REF = TRAS_REF_DEFAULT
) (
  input  logic FCLK,
  input  logic nRESET,
  input  logic ASActive,
  input  logic ASInactive,
  input  logic RAMCS,
  input  logic RnW,
  input  logic nLDS,
  input  logic nUDS,
  input  logic RefReq,
  input  logic RefUrgent,
  output logic RefAck,
  output logic RAMReady,
  output logic nRAS,
  output logic nLCAS,
  output logic nUCAS,
  output logic nRAMWE,
  output logic RASEL
);

  generate
    if (TRP < 1 || TRP > 7 || TRAS_REF < 1 || TRAS_REF > 7) begin : gBadParam
      $error("ram_ctrl: TRP and TRAS_REF must both lie in 1..7");
    end
  endgenerate

  // Counter holds remaining cycles minus one, so a reload of N-1 gives N cycles.
  localparam logic [2:0] TRP_LOAD  = 3'(TRP - 1);
  localparam logic [2:0] TRAS_LOAD = 3'(TRAS_REF - 1);

  ramState_t  state;
  logic [2:0] count;

  always_ff @(posedge FCLK or negedge nRESET) begin
    if (!nRESET) begin
      state    <= IDLE;
      count    <= 3'd0;
      nRAS     <= 1'b1;
      nLCAS    <= 1'b1;
      nUCAS    <= 1'b1;
      nRAMWE   <= 1'b1;
      RASEL    <= 1'b1;
      RAMReady <= 1'b0;
      RefAck   <= 1'b0;
    end else begin
      RefAck <= 1'b0;
      case (state)
        IDLE: begin
          if (RefUrgent) begin
            state <= REFCAS;
            nLCAS <= 1'b0;
            nUCAS <= 1'b0;
          end else if (ASActive && RAMCS) begin
            state  <= RAS;
            nRAS   <= 1'b0;
            nRAMWE <= RnW;
          end else if (RefReq) begin
            state <= REFCAS;
            nLCAS <= 1'b0;
            nUCAS <= 1'b0;
          end
        end

        RAS: begin
          if (ASInactive) begin
            state  <= PRE;
            count  <= TRP_LOAD;
            nRAS   <= 1'b1;
            nRAMWE <= 1'b1;
          end else begin
            state    <= CAS;
            RASEL    <= 1'b0;
            nLCAS    <= nLDS;
            nUCAS    <= nUDS;
            RAMReady <= 1'b1;
          end
        end

        CAS: begin
          if (ASInactive) begin
            state    <= PRE;
            count    <= TRP_LOAD;
            nRAS     <= 1'b1;
            nLCAS    <= 1'b1;
            nUCAS    <= 1'b1;
            nRAMWE   <= 1'b1;
            RASEL    <= 1'b1;
            RAMReady <= 1'b0;
          end else begin
            nLCAS <= nLDS;
            nUCAS <= nUDS;
          end
        end

        PRE: begin
          if (count == 3'd0) state <= IDLE;
          else               count <= count - 3'd1;
        end

        REFCAS: begin
          state <= REFRAS;
          count <= TRAS_LOAD;
          nRAS  <= 1'b0;
        end

        REFRAS: begin
          if (count == 3'd0) begin
            state  <= PRE;
            count  <= TRP_LOAD;
            nRAS   <= 1'b1;
            nLCAS  <= 1'b1;
            nUCAS  <= 1'b1;
            RefAck <= 1'b1;
          end else begin
            count <= count - 3'd1;
          end
        end

        default: begin
          state    <= IDLE;
          count    <= 3'd0;
          nRAS     <= 1'b1;
          nLCAS    <= 1'b1;
          nUCAS    <= 1'b1;
          nRAMWE   <= 1'b1;
          RASEL    <= 1'b1;
          RAMReady <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- DRAM sequencer and arbiter for the MC68HC000 front-side bus.
- Shares the DRAM array between CPU accesses and CAS-before-RAS refresh.
- Consumes the FSB's AS detection and refresh-request outputs. Drives RAS/CAS/WE/row-column select, the RAM ready term and the refresh acknowledge.
- RAMReady is ORed externally with the other ready sources into the FSB Ready input.

Parameters:
- TRP, 2: RAS precharge cycles after any RAS-low period (1..7).
- TRAS_REF, 3: cycles nRAS is held low during refresh (1..7).

Ports:
- FCLK  input  1  system clock; all state changes on posedge.
- nRESET  input  1  asynchronous active-low reset.
- ASActive  input  1  address strobe asserted (from FSB).
- ASInactive  input  1  address strobe fully negated (from FSB).
- RAMCS  input  1  current address decodes to DRAM.
- RnW  input  1  CPU read/not-write.
- nLDS  input  1  CPU lower data strobe.
- nUDS  input  1  CPU upper data strobe.
- RefReq  input  1  refresh owed this period.
- RefUrgent  input  1  refresh overdue; must preempt the CPU.
- RefAck  output  1  one-cycle pulse when a refresh completes.
- RAMReady  output  1  DRAM data valid/accepted; FSB may assert nDTACK.
- nRAS  output  1  DRAM row strobe.
- nLCAS  output  1  DRAM column strobe, low byte.
- nUCAS  output  1  DRAM column strobe, high byte.
- nRAMWE  output  1  DRAM write enable.
- RASEL  output  1  address mux: 1 = row, 0 = column.

Behaviour:
- All outputs are registered.
- Reset (async, nRESET=0), any state: state=IDLE, counter=0, nRAS=nLCAS=nUCAS=nRAMWE=1, RASEL=1, RAMReady=0, RefAck=0. Reset mid-access or mid-refresh aborts immediately with strobes high.
- States: IDLE, RAS, CAS, PRE, REFCAS, REFRAS.
- IDLE: strobes high, RASEL=1. Evaluated in priority order:
  - RefUrgent -> REFCAS.
  - Else ASActive & RAMCS -> RAS. Latch nRAMWE=RnW for the whole access.
  - Else RefReq -> REFCAS. Non-urgent refresh only takes idle or non-RAM bus time.
- RAS: nRAS=0, RASEL=1, one cycle.
  - If ASInactive is seen -> PRE with no RAMReady (aborted cycle).
  - Else -> CAS.
- CAS: RASEL=0, nLCAS=nLDS, nUCAS=nUDS (resampled every cycle), RAMReady=1.
  - Stays in CAS while ~ASInactive.
  - On ASInactive -> PRE. nRAS, CAS, WE and RAMReady all deassert on that edge.
- PRE: strobes high; counter counts TRP cycles, then -> IDLE. No new RAS before TRP elapses, even with a pending request.
- REFCAS: nLCAS=nUCAS=0, nRAS=1, nRAMWE=1, one cycle -> REFRAS.
- REFRAS: CAS still low, nRAS=0 for TRAS_REF cycles.
  - On exit all strobes go high and RefAck=1 for exactly one cycle, then -> PRE.
- Refresh is never interrupted by AS. A CPU cycle arriving during refresh waits (RAMReady=0) and is serviced from IDLE after PRE.
- Worst-case CPU stall = 1 + TRAS_REF + TRP + TRP cycles.
- Simultaneous events in IDLE:
  - RefUrgent & RAM request: refresh wins.
  - RefReq (non-urgent) & RAM request: CPU wins.
- RefReq still high one cycle after RefAck (FSB latency) must not start a second refresh. The PRE stay of at least 1 cycle guarantees this; TRP >= 1 is required.
- At most one RefAck per refresh; RefAck is never asserted outside REFRAS exit.
- Counter is 3 bits, reloaded on entry to PRE/REFRAS. Parameters outside 1..7 are illegal (elaboration assertion).

Decomposition:
- Shared package ram_pkg: state encoding enum (IDLE, RAS, CAS, PRE, REFCAS, REFRAS) and TRP/TRAS_REF defaults, shared with the bench.
- No sub-module; a single FSM plus 3-bit down-counter.

Test Plan:
- Reset then idle 20 cycles -> nRAS/nLCAS/nUCAS/nRAMWE=1, RASEL=1, RAMReady=0, RefAck=0.
- Word read: ASActive=1, RAMCS=1, RnW=1, nLDS=nUDS=0 -> nRAS low cycle 1; RASEL=0, both CAS low, RAMReady=1 cycle 2; ASInactive -> strobes high next edge; no RAS for 2 cycles.
- Byte write, nUDS=0, nLDS=1, RnW=0 -> nRAMWE=0, nUCAS=0, nLCAS=1 throughout CAS.
- RefUrgent=1 coincident with RAM request in IDLE -> REFCAS 1 cycle, nRAS low 3 cycles, RefAck pulse 1 cycle, 2 PRE cycles, then CPU RAS; RAMReady first seen 8 cycles after request.
- RefReq=1 (not urgent) during an ongoing CPU access -> no refresh until ASInactive and PRE complete; then one refresh, exactly one RefAck.
- nRESET asserted in REFRAS -> strobes high asynchronously, RefAck stays 0; after release, state IDLE.
